// File: rtl/mem_io_responder.sv
// Byte-bus responder for the CPU memory port: 128 KiB RAM plus an I/O window
// with UART TX/RX queues, a free-running cycle counter and a sticky stop flag.
module mem_io_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH       = 8,
    parameter int RX_DEPTH       = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        program_done,
    output logic        tx_overflow
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int RX_CW = RX_AW + 1;

    localparam logic [TX_CW-1:0] TX_CNT_FULL = TX_CW'(TX_DEPTH);
    localparam logic [TX_CW-1:0] TX_CNT_HIGH = TX_CW'(TX_DEPTH - 2);
    localparam logic [RX_CW-1:0] RX_CNT_FULL = RX_CW'(RX_DEPTH);

    // Storage arrays (never reset)
    logic [7:0]          r_ram    [1 << RAM_ADDR_WIDTH];
    logic [7:0]          r_tx_mem [TX_DEPTH];
    logic [7:0]          r_rx_mem [RX_DEPTH];
    logic [7:0]          r_ram_rd;

    // Control / state registers
    logic [TX_AW-1:0]    r_tx_wptr;
    logic [TX_AW-1:0]    r_tx_rptr;
    logic [TX_CW-1:0]    r_tx_count;
    logic [RX_AW-1:0]    r_rx_wptr;
    logic [RX_AW-1:0]    r_rx_rptr;
    logic [RX_CW-1:0]    r_rx_count;
    logic [31:0]         r_cycle;
    logic [31:0]         r_snap;
    logic                r_sel_ram;
    logic [7:0]          r_io_rd;
    logic                r_program_done;
    logic                r_tx_overflow;

    logic                       w_is_io;
    logic                       w_io_data;
    logic                       w_io_cnt;
    logic                       w_io_cnt0;
    logic [RAM_ADDR_WIDTH-1:0]  w_ram_addr;
    logic                       w_tx_full;
    logic                       w_tx_pop;
    logic                       w_tx_push_req;
    logic                       w_tx_push;
    logic [7:0]                 w_tx_wdata;
    logic                       w_rx_empty;
    logic                       w_rx_push;
    logic                       w_rx_pop;
    logic [7:0]                 w_io_rd_next;
    logic                       w_unused_addr;

    // Address decode: only bits [17:0] take part
    assign w_is_io    = (mem_a[17:16] == 2'b11);
    assign w_io_data  = w_is_io && (mem_a[15:0] == 16'h0000);
    assign w_io_cnt   = w_is_io && (mem_a[15:2] == 14'h0001);
    assign w_io_cnt0  = w_io_cnt && (mem_a[1:0] == 2'b00);
    assign w_ram_addr = mem_a[RAM_ADDR_WIDTH-1:0];
    assign w_unused_addr = ^mem_a[31:18];

    assign w_tx_full     = (r_tx_count == TX_CNT_FULL);
    assign w_tx_pop      = tx_valid && tx_ready;
    assign w_tx_push_req = mem_wr && ((w_io_data && (mem_dout != 8'h00)) ||
                                      (w_io_cnt0 && !r_program_done));
    assign w_tx_wdata    = w_io_data ? mem_dout : 8'h00;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push
    assign w_tx_push     = w_tx_push_req && (!w_tx_full || w_tx_pop);

    assign w_rx_empty = (r_rx_count == RX_CW'(0));
    assign w_rx_push  = rx_valid && rx_ready;
    assign w_rx_pop   = !mem_wr && w_io_data && !w_rx_empty;

    always_comb begin
        w_io_rd_next = 8'h00;
        if (!mem_wr) begin
            if (w_io_data && !w_rx_empty) begin
                w_io_rd_next = r_rx_mem[r_rx_rptr];
            end else if (w_io_cnt) begin
                case (mem_a[1:0])
                    2'b00:   w_io_rd_next = r_cycle[7:0];
                    2'b01:   w_io_rd_next = r_snap[15:8];
                    2'b10:   w_io_rd_next = r_snap[23:16];
                    default: w_io_rd_next = r_snap[31:24];
                endcase
            end
        end
    end

    // Read-first RAM port; a write followed by a read next cycle sees the new byte
    always_ff @(posedge clk_in) begin
        if (mem_wr && !w_is_io) begin
            r_ram[w_ram_addr] <= mem_dout;
        end
        r_ram_rd <= r_ram[w_ram_addr];
    end

    always_ff @(posedge clk_in) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= w_tx_wdata;
        end
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= rx_data;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_tx_wptr      <= '0;
            r_tx_rptr      <= '0;
            r_tx_count     <= '0;
            r_rx_wptr      <= '0;
            r_rx_rptr      <= '0;
            r_rx_count     <= '0;
            r_cycle        <= 32'd0;
            r_snap         <= 32'd0;
            r_sel_ram      <= 1'b0;
            r_io_rd        <= 8'h00;
            r_program_done <= 1'b0;
            r_tx_overflow  <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;

            if (w_tx_push) begin
                r_tx_wptr <= r_tx_wptr + TX_AW'(1);
            end
            if (w_tx_pop) begin
                r_tx_rptr <= r_tx_rptr + TX_AW'(1);
            end
            if (w_tx_push && !w_tx_pop) begin
                r_tx_count <= r_tx_count + TX_CW'(1);
            end else if (!w_tx_push && w_tx_pop) begin
                r_tx_count <= r_tx_count - TX_CW'(1);
            end
            if (w_tx_push_req && w_tx_full && !w_tx_pop) begin
                r_tx_overflow <= 1'b1;
            end
            if (mem_wr && w_io_cnt0) begin
                r_program_done <= 1'b1;
            end

            if (w_rx_push) begin
                r_rx_wptr <= r_rx_wptr + RX_AW'(1);
            end
            if (w_rx_pop) begin
                r_rx_rptr <= r_rx_rptr + RX_AW'(1);
            end
            if (w_rx_push && !w_rx_pop) begin
                r_rx_count <= r_rx_count + RX_CW'(1);
            end else if (!w_rx_push && w_rx_pop) begin
                r_rx_count <= r_rx_count - RX_CW'(1);
            end

            // Snapshot and byte 0 come from the same counter value
            if (!mem_wr && w_io_cnt0) begin
                r_snap <= r_cycle;
            end
            r_sel_ram <= !w_is_io;
            r_io_rd   <= w_io_rd_next;
        end
    end

    assign mem_din        = r_sel_ram ? r_ram_rd : r_io_rd;
    assign tx_valid       = (r_tx_count != TX_CW'(0));
    assign tx_data        = tx_valid ? r_tx_mem[r_tx_rptr] : 8'h00;
    assign io_buffer_full = (r_tx_count >= TX_CNT_HIGH);
    assign rx_ready       = (r_rx_count != RX_CNT_FULL);
    assign program_done   = r_program_done;
    assign tx_overflow    = r_tx_overflow;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: vector table plus hand-written
// sequences for FIFO fill/drain, counter snapshot, stop flag and reset.
module tb_mem_io_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        program_done;
    logic        tx_overflow;

    int checks   = 0;
    int failures = 0;

    mem_io_responder dut (
        .clk_in(clk_in), .rst_in(rst_in), .mem_a(mem_a), .mem_dout(mem_dout),
        .mem_wr(mem_wr), .mem_din(mem_din), .io_buffer_full(io_buffer_full),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .program_done(program_done), .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
        logic        wr;
        logic        txr;
        logic        rxv;
        logic [7:0]  rxd;
        logic        chk_din;
        logic [7:0]  din;
        logic        txv;
        logic [7:0]  txd;
        logic        bfull;
        logic        rxr;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] a, input logic [7:0] d, input logic wr,
                                input logic txr, input logic rxv, input logic [7:0] rxd,
                                input logic chk_din, input logic [7:0] din,
                                input logic txv, input logic [7:0] txd,
                                input logic bfull, input logic rxr);
        vec_t v;
        v.a = a; v.d = d; v.wr = wr; v.txr = txr; v.rxv = rxv; v.rxd = rxd;
        v.chk_din = chk_din; v.din = din; v.txv = txv; v.txd = txd;
        v.bfull = bfull; v.rxr = rxr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One bus access: inputs applied after a falling edge, outputs sampled at the next one
    task automatic step(input logic [31:0] a, input logic [7:0] d, input logic wr);
        mem_a = a; mem_dout = d; mem_wr = wr;
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        rst_in = 1'b1; mem_a = 32'h0; mem_dout = 8'h0; mem_wr = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    vec_t tbl[19];
    logic [7:0]  b[4];
    logic [31:0] v, prev;
    logic [7:0]  drain_exp[8];

    initial begin
        tbl[0]  = mk(32'h00010,    8'hA5, 1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1);
        tbl[1]  = mk(32'h00010,    8'h00, 0, 0, 0, 8'h00, 1, 8'hA5, 0, 8'h00, 0, 1);
        tbl[2]  = mk(32'h1FFFF,    8'h3C, 1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1);
        tbl[3]  = mk(32'h1FFFF,    8'h00, 0, 0, 0, 8'h00, 1, 8'h3C, 0, 8'h00, 0, 1);
        tbl[4]  = mk(32'hFFFC0010, 8'h00, 0, 0, 0, 8'h00, 1, 8'hA5, 0, 8'h00, 0, 1);
        tbl[5]  = mk(32'h30000,    8'h41, 1, 0, 0, 8'h00, 0, 8'h00, 1, 8'h41, 0, 1);
        tbl[6]  = mk(32'h30000,    8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 1, 8'h41, 0, 1);
        tbl[7]  = mk(32'h00000,    8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1);
        tbl[8]  = mk(32'h00010,    8'h00, 0, 0, 1, 8'h55, 1, 8'hA5, 0, 8'h00, 0, 1);
        tbl[9]  = mk(32'h30000,    8'h00, 0, 0, 0, 8'h00, 1, 8'h55, 0, 8'h00, 0, 1);
        tbl[10] = mk(32'h30000,    8'h00, 0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0, 1);
        tbl[11] = mk(32'h30008,    8'h00, 0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0, 1);
        tbl[12] = mk(32'h30008,    8'h77, 1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1);
        tbl[13] = mk(32'h30005,    8'h00, 0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0, 1);
        tbl[14] = mk(32'h30000,    8'h00, 0, 0, 1, 8'h66, 1, 8'h00, 0, 8'h00, 0, 1);
        tbl[15] = mk(32'h30000,    8'h00, 0, 0, 0, 8'h00, 1, 8'h66, 0, 8'h00, 0, 1);
        tbl[16] = mk(32'h30000,    8'h00, 0, 0, 0, 8'h00, 1, 8'h00, 0, 8'h00, 0, 1);
        tbl[17] = mk(32'h20000,    8'h5A, 1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 1);
        tbl[18] = mk(32'h20000,    8'h00, 0, 0, 0, 8'h00, 1, 8'h5A, 0, 8'h00, 0, 1);

        // Reset values
        rst_in = 1'b1; mem_a = 32'h0; mem_dout = 8'h0; mem_wr = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_mem_din", mem_din, 8'h00);
        chk("rst_io_buffer_full", io_buffer_full, 1'b0);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_rx_ready", rx_ready, 1'b1);
        chk("rst_program_done", program_done, 1'b0);
        chk("rst_tx_overflow", tx_overflow, 1'b0);
        rst_in = 1'b0;

        for (int i = 0; i < 19; i++) begin
            tx_ready = tbl[i].txr; rx_valid = tbl[i].rxv; rx_data = tbl[i].rxd;
            step(tbl[i].a, tbl[i].d, tbl[i].wr);
            if (tbl[i].chk_din) chk($sformatf("vec%0d_mem_din", i), mem_din, tbl[i].din);
            chk($sformatf("vec%0d_tx_valid", i), tx_valid, tbl[i].txv);
            if (tbl[i].txv) chk($sformatf("vec%0d_tx_data", i), tx_data, tbl[i].txd);
            chk($sformatf("vec%0d_io_buffer_full", i), io_buffer_full, tbl[i].bfull);
            chk($sformatf("vec%0d_rx_ready", i), rx_ready, tbl[i].rxr);
        end
        tx_ready = 1'b0; rx_valid = 1'b0;

        // TX fill, simultaneous push/pop on full, overflow, ordered drain
        for (int i = 1; i <= 8; i++) begin
            step(32'h30000, 8'(i), 1'b1);
            if (i == 5) chk("tx_bfull_after5", io_buffer_full, 1'b0);
            if (i == 6) chk("tx_bfull_after6", io_buffer_full, 1'b1);
        end
        chk("tx_full_no_ovf", tx_overflow, 1'b0);
        tx_ready = 1'b1;
        step(32'h30000, 8'h0A, 1'b1);
        tx_ready = 1'b0;
        chk("tx_pushpop_full_no_ovf", tx_overflow, 1'b0);
        chk("tx_pushpop_head", tx_data, 8'h02);
        step(32'h30000, 8'h0B, 1'b1);
        chk("tx_overflow_set", tx_overflow, 1'b1);
        drain_exp = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0A};
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d_valid", i), tx_valid, 1'b1);
            chk($sformatf("drain%0d_data", i), tx_data, drain_exp[i]);
            tx_ready = 1'b1;
            step(32'h0, 8'h0, 1'b0);
            tx_ready = 1'b0;
        end
        chk("drain_empty", tx_valid, 1'b0);
        chk("drain_bfull_low", io_buffer_full, 1'b0);

        // RX fill to full, blocked push, ordered CPU reads
        rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_data = 8'h80 + 8'(i);
            step(32'h00010, 8'h0, 1'b0);
            chk($sformatf("rx_fill%0d_ready", i), rx_ready, (i < 7) ? 1'b1 : 1'b0);
        end
        rx_data = 8'hFF;
        step(32'h00010, 8'h0, 1'b0);
        rx_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(32'h30000, 8'h0, 1'b0);
            chk($sformatf("rx_read%0d", i), mem_din, 8'h80 + 8'(i));
            if (i == 0) chk("rx_ready_after_pop", rx_ready, 1'b1);
        end
        step(32'h30000, 8'h0, 1'b0);
        chk("rx_read_empty", mem_din, 8'h00);

        // Cycle counter snapshot consistency
        do_reset();
        repeat (1000) @(posedge clk_in);
        @(negedge clk_in);
        for (int k = 0; k < 4; k++) begin
            step(32'h30004 + 32'(k), 8'h0, 1'b0);
            b[k] = mem_din;
        end
        v = {b[3], b[2], b[1], b[0]};
        chk("cnt_range_1000", (v >= 32'd999 && v <= 32'd1001) ? 32'd1 : 32'd0, 32'd1);
        prev = v;
        for (int n = 0; n < 70; n++) begin
            for (int k = 0; k < 4; k++) begin
                step(32'h30004 + 32'(k), 8'h0, 1'b0);
                b[k] = mem_din;
            end
            v = {b[3], b[2], b[1], b[0]};
            chk($sformatf("cnt_delta%0d", n), v - prev, 32'd4);
            prev = v;
        end

        // Counter wrap
        force dut.r_cycle = 32'hFFFF_FFFF;
        #1;
        release dut.r_cycle;
        step(32'h30004, 8'h0, 1'b0);
        chk("wrap_byte0", mem_din, 8'hFF);
        step(32'h30007, 8'h0, 1'b0);
        chk("wrap_snap_byte3", mem_din, 8'hFF);
        step(32'h30004, 8'h0, 1'b0);
        chk("wrap_live_byte0", mem_din, 8'h01);
        step(32'h30005, 8'h0, 1'b0);
        chk("wrap_live_byte1", mem_din, 8'h00);

        // Program stop flag
        do_reset();
        step(32'h30004, 8'h12, 1'b1);
        chk("done_set", program_done, 1'b1);
        chk("done_tx_valid", tx_valid, 1'b1);
        chk("done_tx_data", tx_data, 8'h00);
        step(32'h30004, 8'h34, 1'b1);
        chk("done_sticky", program_done, 1'b1);
        tx_ready = 1'b1;
        step(32'h0, 8'h0, 1'b0);
        tx_ready = 1'b0;
        chk("done_single_byte", tx_valid, 1'b0);

        // Asynchronous reset mid-operation
        step(32'h30000, 8'h11, 1'b1);
        step(32'h30000, 8'h22, 1'b1);
        step(32'h30000, 8'h33, 1'b1);
        rx_valid = 1'b1; rx_data = 8'h99;
        step(32'h00010, 8'h0, 1'b0);
        rx_valid = 1'b0;
        step(32'h30004, 8'h0, 1'b0);
        chk("pre_rst_tx_valid", tx_valid, 1'b1);
        rst_in = 1'b1;
        #1;
        chk("midrst_tx_valid", tx_valid, 1'b0);
        chk("midrst_program_done", program_done, 1'b0);
        chk("midrst_mem_din", mem_din, 8'h00);
        chk("midrst_io_buffer_full", io_buffer_full, 1'b0);
        chk("midrst_tx_overflow", tx_overflow, 1'b0);
        chk("midrst_rx_ready", rx_ready, 1'b1);
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        step(32'h30000, 8'h0, 1'b0);
        chk("post_rst_rx_empty", mem_din, 8'h00);
        chk("post_rst_tx_empty", tx_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
